// File: rtl/led_blink_decoder.sv
`timescale 1ns/1ps
// led_blink_decoder
//   Recovers a 2-bit select code from the blink rate of an LED waveform.
//   The time between edges of led_in_i is compared against four half-periods.
//   Two consecutive intervals with the same code are needed to lock onto it.
//
// Ports
//   clk_i      single clock, rising edge
//   rst_ni     asynchronous, active-low reset
//   led_in_i   asynchronous LED waveform
//   code_o     decoded select {s1,s2}; holds its last locked value
//   valid_o    high while locked to a rate
//   lost_o     high while no edge has been seen for 2^CW-1 cycles
//   err_o      one-cycle pulse for an interval that matches no code
//
// Optional feature
//   LED_BLINK_DECODER_GLITCH_FILTER_EN: adds a 3-sample glitch filter after
//   the synchronizer. This adds 2 cycles of edge latency.
//
// state   | meaning
// IDLE    | no reference edge yet; the next edge only starts timing
// MEASURE | collecting matching intervals; a candidate code may be held
// LOCKED  | two consecutive intervals agreed; code_o/valid_o are driven
module led_blink_decoder #(
  parameter int unsigned CW  = 8,
  parameter int unsigned HP0 = 100,
  parameter int unsigned HP1 = 50,
  parameter int unsigned HP2 = 10,
  parameter int unsigned HP3 = 1,
  parameter int unsigned TOL = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       led_in_i,
  output logic [1:0] code_o,
  output logic       valid_o,
  output logic       lost_o,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic near(input logic [CW-1:0] iv, input int unsigned hp);
    int unsigned ivw;
    ivw = 32'(iv);
    return (ivw + TOL >= hp) && (ivw <= hp + TOL);
  endfunction

  logic [1:0]    sync_q;
  logic          led_s;
  logic          level_d, level_q;
  logic          edge_det;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          sat;
  logic          hit;
  logic [1:0]    hit_k;
  state_e        state_d, state_q;
  logic [1:0]    cand_d, cand_q;
  logic          cand_vld_d, cand_vld_q;
  logic [1:0]    code_d, code_q;
  logic          valid_d, valid_q;
  logic          lost_d, lost_q;
  logic          err_d, err_q;

  assign led_s = sync_q[1];

`ifdef LED_BLINK_DECODER_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  // The filtered level only moves once three samples in a row agree.
  // It is used combinationally, so the edge costs 2 cycles and not 3.
  always_comb begin
    level_d = level_q;
    if ((led_s == hist_q[0]) && (led_s == hist_q[1])) level_d = led_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= 2'b00;
    else         hist_q <= {hist_q[0], led_s};
  end
`else
  always_comb level_d = led_s;
`endif

  assign edge_det = level_d ^ level_q;
  assign sat      = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_det)  cnt_d = CW'(1);
    else if (!sat) cnt_d = cnt_q + CW'(1);
  end

  // If several codes match, the lowest code is selected.
  // A saturated count does not give a real interval, so it never matches.
  always_comb begin
    hit   = 1'b0;
    hit_k = 2'd0;
    if (!sat) begin
      if (near(cnt_q, HP0))      begin hit = 1'b1; hit_k = 2'd0; end
      else if (near(cnt_q, HP1)) begin hit = 1'b1; hit_k = 2'd1; end
      else if (near(cnt_q, HP2)) begin hit = 1'b1; hit_k = 2'd2; end
      else if (near(cnt_q, HP3)) begin hit = 1'b1; hit_k = 2'd3; end
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    code_d     = code_q;
    valid_d    = valid_q;
    lost_d     = lost_q;
    err_d      = 1'b0;
    if (edge_det) begin
      lost_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          state_d    = MEASURE;
          cand_vld_d = 1'b0;
        end
        MEASURE: begin
          if (hit && cand_vld_q && (cand_q == hit_k)) begin
            state_d = LOCKED;
            code_d  = hit_k;
            valid_d = 1'b1;
          end else if (hit) begin
            cand_d     = hit_k;
            cand_vld_d = 1'b1;
          end else begin
            cand_vld_d = 1'b0;
            err_d      = 1'b1;
          end
        end
        LOCKED: begin
          if (hit && (hit_k != cand_q)) begin
            state_d    = MEASURE;
            valid_d    = 1'b0;
            cand_d     = hit_k;
            cand_vld_d = 1'b1;
          end else if (!hit) begin
            state_d    = MEASURE;
            valid_d    = 1'b0;
            cand_vld_d = 1'b0;
            err_d      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (sat) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      cand_vld_d = 1'b0;
      lost_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= 2'b00;
      level_q    <= 1'b0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      cand_q     <= 2'd0;
      cand_vld_q <= 1'b0;
      code_q     <= 2'd0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], led_in_i};
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
      err_q      <= err_d;
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign lost_o  = lost_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_led_blink_decoder.sv
`timescale 1ns/1ps
// Directed bench for led_blink_decoder with the default parameters.
// The LED input is driven on falling clock edges and outputs are sampled on falling edges.
// LAT is the number of falling edges from an LED toggle to the registered result.
module tb_led_blink_decoder;

`ifdef LED_BLINK_DECODER_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       led = 1'b0;
  logic [1:0] code;
  logic       valid, lost, err;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  int e0 = 0;
  bit lost_seen = 1'b0;

  always #5 clk = ~clk;

  led_blink_decoder dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .led_in_i(led),
    .code_o  (code),
    .valid_o (valid),
    .lost_o  (lost),
    .err_o   (err)
  );

  always @(negedge clk) begin
    if (err)  err_pulses++;
    if (lost) lost_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tgl();
    led = ~led;
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_code", 32'(code), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_lost", 32'(lost), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    // lock at 100: valid one cycle after the third synchronized edge
    tgl(); cyc(100);
    tgl(); cyc(100);
    tgl(); cyc(LAT-1);
    chk("lock100_pre", 32'(valid), 0);
    cyc(1);
    chk("lock100_valid", 32'(valid), 1);
    chk("lock100_code", 32'(code), 0);
    cyc(100-LAT);
    tgl(); cyc(100);
    tgl(); cyc(100);
    chk("lock100_hold", 32'(valid), 1);
    chk("lock100_noerr", 32'(err_pulses), 0);

    // switch 100 -> 10
    tgl(); cyc(10);
    tgl(); cyc(LAT);
    chk("sw10_first_valid", 32'(valid), 0);
    chk("sw10_code_hold", 32'(code), 0);
    cyc(10-LAT);
    tgl(); cyc(LAT);
    chk("sw10_valid", 32'(valid), 1);
    chk("sw10_code", 32'(code), 2);
    cyc(10-LAT);
    chk("sw10_noerr", 32'(err_pulses), 0);

    // hold input steady -> lost, then relock at 50
    cyc(300);
    chk("hold_lost", 32'(lost), 1);
    chk("hold_valid", 32'(valid), 0);
    tgl(); cyc(LAT);
    chk("hold_lost_clr", 32'(lost), 0);
    cyc(50-LAT);
    tgl(); cyc(LAT);
    chk("relock50_first", 32'(valid), 0);
    cyc(50-LAT);
    tgl(); cyc(LAT);
    chk("relock50_valid", 32'(valid), 1);
    chk("relock50_code", 32'(code), 1);
    cyc(50-LAT);

    // edge arrives exactly when the counter saturates (interval 255)
    lost_seen = 1'b0;
    e0 = err_pulses;
    cyc(205);
    tgl(); cyc(LAT);
    chk("sat_edge_valid", 32'(valid), 0);
    chk("sat_edge_lost", 32'(lost), 0);
    cyc(1);
    chk("sat_edge_lost_seen", 32'(lost_seen), 0);
    chk("sat_edge_err", 32'(err_pulses - e0), 1);

    // 75-cycle toggle matches nothing
    cyc(75-LAT-1);
    e0 = err_pulses;
    repeat (4) begin
      tgl(); cyc(LAT);
      chk("r75_valid", 32'(valid), 0);
      cyc(75-LAT);
    end
    chk("r75_err", 32'(err_pulses - e0), 4);

    // tolerance edge: 101 locks to code 00, 102 does not
    cyc(26);
    tgl(); cyc(101);
    tgl(); cyc(LAT);
    chk("r101_valid", 32'(valid), 1);
    chk("r101_code", 32'(code), 0);
    cyc(102-LAT);
    e0 = err_pulses;
    repeat (3) begin
      tgl(); cyc(LAT);
      chk("r102_valid", 32'(valid), 0);
      cyc(102-LAT);
    end
    chk("r102_err", 32'(err_pulses - e0), 3);

    // lock at 50, then reset mid-lock
    tgl(); cyc(50);
    tgl(); cyc(50);
    tgl(); cyc(LAT);
    chk("pre_rst_valid", 32'(valid), 1);
    chk("pre_rst_code", 32'(code), 1);
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_code", 32'(code), 0);
    chk("rst_mid_valid", 32'(valid), 0);
    cyc(3);
    led = 1'b0;
    rst_n = 1'b1;

    // relock after reset needs three fresh edges
    tgl(); cyc(50);
    chk("post_rst_e1", 32'(valid), 0);
    tgl(); cyc(LAT);
    chk("post_rst_e2", 32'(valid), 0);
    cyc(50-LAT);
    tgl(); cyc(LAT);
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_code", 32'(code), 1);
    e0 = err_pulses;
`ifdef LED_BLINK_DECODER_GLITCH_FILTER_EN
    // one-cycle glitch inside the 50-cycle stream
    cyc(20-LAT);
    led = ~led; cyc(1);
    led = ~led; cyc(29);
`else
    cyc(50-LAT);
`endif
    tgl(); cyc(LAT);
    chk("stream50_valid", 32'(valid), 1);
    chk("stream50_code", 32'(code), 1);
    cyc(2);
    chk("stream50_noerr", 32'(err_pulses - e0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
